// File: rtl/cpu_pkg.sv
// Shared decode types for the operand-issue slice: R-type fields,
// scoreboard entries and an instruction-word unpacker.
package cpu_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam int OPC_LO = 0;
  localparam int RD_LO  = 7;
  localparam int F3_LO  = 12;
  localparam int RS1_LO = 15;
  localparam int RS2_LO = 20;
  localparam int F7_LO  = 25;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic rtype_t decode(logic [31:0] w);
    rtype_t r;
    r.funct7 = w[F7_LO +: 7];
    r.rs2    = w[RS2_LO +: 5];
    r.rs1    = w[RS1_LO +: 5];
    r.funct3 = w[F3_LO +: 3];
    r.rd     = w[RD_LO +: 5];
    r.opcode = w[OPC_LO +: 7];
    return r;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file: two async read ports, writeback port and a
// debug preload port; writeback wins on an address collision.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata
);

  logic [XLEN-1:0] mem [32];

  // Debug write first so a same-address writeback overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (dbg_we && dbg_addr != 5'd0) begin
        mem[dbg_addr] <= dbg_wdata;
      end
      if (we && wa != 5'd0) begin
        mem[wa] <= wd;
      end
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/operand_issue.sv
// Operand fetch / issue stage with a writeback scoreboard.
// Define OPISSUE_FWD_EN to bypass y into a dependent issuing in the retire cycle.
module operand_issue
  import cpu_pkg::*;
#(
  parameter int EXEC_LAT = 1,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic            issue_valid,
  input  logic [XLEN-1:0] y,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic            illegal,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata
);

  rtype_t ins;
  assign ins = decode(in_instr);

  sb_entry_t sb [EXEC_LAT];
  sb_entry_t tail;
  assign tail = sb[EXEC_LAT-1];

  logic [XLEN-1:0] rf1;
  logic [XLEN-1:0] rf2;

  regfile_2r1w #(.XLEN(XLEN)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (ins.rs1),
    .rd1      (rf1),
    .ra2      (ins.rs2),
    .rd2      (rf2),
    .we       (tail.valid),
    .wa       (tail.rd),
    .wd       (y),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata)
  );

  logic young1;
  logic young2;
  logic tail1;
  logic tail2;
  logic hazard;
  logic fwd1;
  logic fwd2;

  // Entries younger than the tail are still executing and always block.
  always_comb begin
    young1 = 1'b0;
    young2 = 1'b0;
    for (int i = 0; i < EXEC_LAT - 1; i++) begin
      if (sb[i].valid && ins.rs1 != 5'd0 && sb[i].rd == ins.rs1) begin
        young1 = 1'b1;
      end
      if (sb[i].valid && ins.rs2 != 5'd0 && sb[i].rd == ins.rs2) begin
        young2 = 1'b1;
      end
    end
  end

  assign tail1 = tail.valid && ins.rs1 != 5'd0 && tail.rd == ins.rs1;
  assign tail2 = tail.valid && ins.rs2 != 5'd0 && tail.rd == ins.rs2;

`ifdef OPISSUE_FWD_EN
  assign hazard = young1 | young2;
  assign fwd1   = tail1;
  assign fwd2   = tail2;
`else
  assign hazard = young1 | young2 | tail1 | tail2;
  assign fwd1   = 1'b0;
  assign fwd2   = 1'b0;
`endif

  assign in_ready = !hazard;

  logic accept;
  logic legal;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;

  assign accept = in_valid && in_ready;
  assign legal  = ins.opcode == OPC_RTYPE;
  assign a_next = fwd1 ? y : rf1;
  assign b_next = fwd2 ? y : rf2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= '0;
      a           <= '0;
      b           <= '0;
      issue_valid <= 1'b0;
      illegal     <= 1'b0;
      for (int i = 0; i < EXEC_LAT; i++) begin
        sb[i] <= '0;
      end
    end else begin
      issue_valid <= accept && legal;
      illegal     <= accept && !legal;
      if (accept && legal) begin
        instruction <= ins;
        a           <= a_next;
        b           <= b_next;
        sb[0]       <= '{valid: (ins.rd != 5'd0), rd: ins.rd};
      end else begin
        sb[0] <= '0;
      end
      for (int i = 1; i < EXEC_LAT; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

  assign retire_valid = tail.valid;
  assign retire_rd    = tail.rd;

endmodule

// File: tb/tb_operand_issue.sv
// Randomized and directed bench for operand_issue against a
// cycle-indexed model of pending writebacks and register contents.
module tb_operand_issue;
  localparam int LAT = 1;
  localparam int XL  = 32;
`ifdef OPISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready;
  logic [31:0] instruction;
  logic [XL-1:0] a;
  logic [XL-1:0] b;
  logic issue_valid;
  logic [XL-1:0] y = '0;
  logic retire_valid;
  logic [4:0] retire_rd;
  logic illegal;
  logic dbg_we = 1'b0;
  logic [4:0] dbg_addr = '0;
  logic [XL-1:0] dbg_wdata = '0;

  always #5 clk = ~clk;

  operand_issue #(.EXEC_LAT(LAT), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .instruction(instruction), .a(a), .b(b), .issue_valid(issue_valid),
    .y(y), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .illegal(illegal),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata)
  );

  typedef struct {
    logic [4:0] rd;
    int wb;
  } pend_t;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  logic [31:0] mrf [32];
  pend_t pend [$];

  logic exp_ready, exp_rv, exp_iv, exp_ill;
  logic [4:0] exp_rrd;
  logic [31:0] exp_instr, exp_a, exp_b, nxt_a, nxt_b;
  logic obs_ready, obs_rv, obs_iv, obs_ill;
  logic [4:0] obs_rrd;
  logic [31:0] obs_instr, obs_a, obs_b;

  function automatic logic [31:0] rt(logic [6:0] f7, logic [4:0] s2,
                                     logic [4:0] s1, logic [2:0] f3,
                                     logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    pend.delete();
    exp_iv = 0; exp_ill = 0; exp_instr = '0; exp_a = '0; exp_b = '0;
  endtask

  // Pending writeback retires in cycle wb; writes RF at the end of it.
  task automatic model_eval();
    logic [4:0] s1, s2;
    bit y1, y2, t1, t2;
    s1 = in_instr[19:15];
    s2 = in_instr[24:20];
    y1 = 0; y2 = 0; t1 = 0; t2 = 0;
    exp_rv = 0; exp_rrd = '0;
    foreach (pend[i]) begin
      if (pend[i].wb == cyc) begin
        exp_rv = 1; exp_rrd = pend[i].rd;
      end
      if (pend[i].wb >= cyc) begin
        if (s1 != 0 && pend[i].rd == s1) begin
          if (pend[i].wb == cyc) t1 = 1; else y1 = 1;
        end
        if (s2 != 0 && pend[i].rd == s2) begin
          if (pend[i].wb == cyc) t2 = 1; else y2 = 1;
        end
      end
    end
    exp_ready = !(y1 || y2 || (!FWD && (t1 || t2)));
    nxt_a = (s1 == 0) ? '0 : (FWD && t1) ? y : mrf[s1];
    nxt_b = (s2 == 0) ? '0 : (FWD && t2) ? y : mrf[s2];
  endtask

  task automatic model_edge();
    if (in_valid && exp_ready) begin
      if (in_instr[6:0] == 7'b0110011) begin
        exp_iv = 1; exp_ill = 0;
        exp_instr = in_instr; exp_a = nxt_a; exp_b = nxt_b;
        if (in_instr[11:7] != 0)
          pend.push_back('{rd: in_instr[11:7], wb: cyc + LAT});
      end else begin
        exp_iv = 0; exp_ill = 1;
      end
    end else begin
      exp_iv = 0; exp_ill = 0;
    end
    if (dbg_we && dbg_addr != 0) mrf[dbg_addr] = dbg_wdata;
    if (exp_rv) mrf[exp_rrd] = y;
    while (pend.size() > 0 && pend[0].wb <= cyc) void'(pend.pop_front());
    cyc++;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic run_cycle(input logic v, input logic [31:0] ins,
                           input logic [31:0] yv, input logic we,
                           input logic [4:0] da, input logic [31:0] dd);
    in_valid = v; in_instr = ins; y = yv;
    dbg_we = we; dbg_addr = da; dbg_wdata = dd;
    model_eval();
    #2;
    obs_ready = in_ready; obs_rv = retire_valid; obs_rrd = retire_rd;
    @(posedge clk);
    model_edge();
    #1;
    obs_iv = issue_valid; obs_ill = illegal;
    obs_a = a; obs_b = b; obs_instr = instruction;
    in_valid = 0; dbg_we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, '0, '0, 0, '0, '0);
  endtask

  task automatic dbg_write(input logic [4:0] ad, input logic [31:0] d);
    run_cycle(0, '0, '0, 1, ad, d);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready got %b exp 1", in_ready);
    end
    nchk++;
    if ({issue_valid, retire_valid, illegal, retire_rd, instruction, a, b} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got iv=%b rv=%b ill=%b rrd=%0d ins=%h a=%h b=%h exp all 0",
               issue_valid, retire_valid, illegal, retire_rd, instruction, a, b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    dbg_write(1, 32'h0F);
    dbg_write(2, 32'h0C);
    run_cycle(1, 32'h002081B3, '0, 0, '0, '0);
    nchk++;
    if (obs_iv !== 1'b1 || obs_a !== 32'h0F || obs_b !== 32'h0C || obs_instr !== 32'h002081B3) begin
      nerr++;
      $display("FAIL add_issue got iv=%b a=%h b=%h ins=%h exp 1 0f 0c 002081b3",
               obs_iv, obs_a, obs_b, obs_instr);
    end
    for (int k = 1; k <= LAT; k++) begin
      run_cycle(0, '0, (k == LAT) ? 32'h1B : 32'h55, 0, '0, '0);
      if (k == LAT) begin
        nchk++;
        if (obs_rv !== 1'b1 || obs_rrd !== 5'd3) begin
          nerr++; $display("FAIL add_retire got rv=%b rd=%0d exp 1 3", obs_rv, obs_rrd);
        end
      end
    end
    run_cycle(1, rt(0, 0, 3, 0, 6), '0, 0, '0, '0);
    nchk++;
    if (obs_a !== 32'h1B) begin
      nerr++; $display("FAIL add_rf3 got %h exp 1b", obs_a);
    end
    idle(LAT + 1);
  endtask

  task automatic test_dependent();
    int stall;
    bit acc;
    dbg_write(3, 32'h0);
    run_cycle(1, 32'h002081B3, '0, 0, '0, '0);
    stall = 0; acc = 0;
    for (int k = 0; k < 10 && !acc; k++) begin
      run_cycle(1, 32'h40118233, 32'h1B, 0, '0, '0);
      if (obs_ready) acc = 1; else stall++;
    end
    nchk++;
    if (!acc) begin
      nerr++; $display("FAIL dep_timeout got no accept exp accept within 10 cycles");
    end
    nchk++;
    if (stall != (FWD ? LAT - 1 : LAT)) begin
      nerr++; $display("FAIL dep_stall got %0d exp %0d", stall, FWD ? LAT - 1 : LAT);
    end
    nchk++;
    if (obs_iv !== 1'b1 || obs_a !== 32'h1B || obs_b !== 32'h0F) begin
      nerr++; $display("FAIL dep_operands got iv=%b a=%h b=%h exp 1 1b 0f", obs_iv, obs_a, obs_b);
    end
    idle(LAT + 1);
  endtask

  task automatic test_x0();
    run_cycle(1, rt(0, 2, 1, 0, 0), '0, 0, '0, '0);
    run_cycle(1, rt(0, 1, 0, 0, 5), 32'h77, 0, '0, '0);
    nchk++;
    if (obs_ready !== 1'b1 || obs_iv !== 1'b1 || obs_a !== 32'h0 || obs_b !== 32'h0F) begin
      nerr++;
      $display("FAIL x0_nostall got rdy=%b iv=%b a=%h b=%h exp 1 1 0 0f",
               obs_ready, obs_iv, obs_a, obs_b);
    end
    nchk++;
    if (obs_rv !== (LAT == 1 ? 1'b0 : obs_rv)) begin
      nerr++; $display("FAIL x0_retire got %b exp 0", obs_rv);
    end
    for (int k = 1; k < LAT; k++) begin
      run_cycle(0, '0, '0, 0, '0, '0);
      nchk++;
      if (obs_rv !== 1'b0) begin
        nerr++; $display("FAIL x0_retire_late got %b exp 0", obs_rv);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] prev;
    prev = rt(0, 1, 0, 0, 5);
    run_cycle(1, 32'h00000013, '0, 0, '0, '0);
    nchk++;
    if (obs_ill !== 1'b1 || obs_iv !== 1'b0) begin
      nerr++; $display("FAIL illegal_pulse got ill=%b iv=%b exp 1 0", obs_ill, obs_iv);
    end
    nchk++;
    if (obs_instr !== prev || obs_a !== 32'h0 || obs_b !== 32'h0F) begin
      nerr++;
      $display("FAIL illegal_hold got ins=%h a=%h b=%h exp %h 0 0f", obs_instr, obs_a, obs_b, prev);
    end
    run_cycle(0, '0, '0, 0, '0, '0);
    nchk++;
    if (obs_ill !== 1'b0) begin
      nerr++; $display("FAIL illegal_oneshot got %b exp 0", obs_ill);
    end
    idle(LAT + 1);
  endtask

  task automatic test_dbg_collision();
    run_cycle(1, 32'h002081B3, '0, 0, '0, '0);
    for (int k = 1; k <= LAT; k++)
      run_cycle(0, '0, 32'h1B, k == LAT, 5'd3, 32'hDEAD);
    run_cycle(1, rt(0, 0, 3, 0, 6), '0, 0, '0, '0);
    nchk++;
    if (obs_a !== 32'h1B) begin
      nerr++; $display("FAIL dbg_collision got %h exp 1b", obs_a);
    end
    idle(LAT + 1);
  endtask

  task automatic test_reset_midflight();
    run_cycle(1, 32'h002081B3, 32'h1B, 0, '0, '0);
    y = 32'h1B;
    rst = 1;
    #1;
    nchk++;
    if ({issue_valid, retire_valid, illegal, retire_rd, instruction, a, b} !== '0) begin
      nerr++;
      $display("FAIL midreset_outputs got iv=%b rv=%b ill=%b rrd=%0d ins=%h a=%h b=%h exp all 0",
               issue_valid, retire_valid, illegal, retire_rd, instruction, a, b);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    dbg_write(1, 32'h5);
    run_cycle(1, rt(0, 1, 3, 0, 6), '0, 0, '0, '0);
    nchk++;
    if (obs_a !== 32'h0 || obs_b !== 32'h5) begin
      nerr++; $display("FAIL midreset_rf got a=%h b=%h exp 0 5", obs_a, obs_b);
    end
    idle(LAT + 1);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int r = 1; r < 8; r++) dbg_write(5'(r), $urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 85) begin
        ins = rt(7'($urandom_range(0, 127)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
      end else begin
        ins = $urandom;
        if (ins[6:0] == 7'b0110011) ins[6:0] = 7'b0010011;
      end
      run_cycle($urandom_range(0, 99) < 75, ins, $urandom,
                $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)), $urandom);
      nchk++;
      if (obs_ready !== exp_ready) begin
        nerr++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, obs_ready, exp_ready);
      end
      nchk++;
      if (obs_rv !== exp_rv || obs_rrd !== exp_rrd) begin
        nerr++;
        $display("FAIL rand_retire cyc=%0d got %b/%0d exp %b/%0d", cyc, obs_rv, obs_rrd, exp_rv, exp_rrd);
      end
      nchk++;
      if (obs_iv !== exp_iv || obs_ill !== exp_ill) begin
        nerr++;
        $display("FAIL rand_pulse cyc=%0d got iv=%b ill=%b exp %b %b", cyc, obs_iv, obs_ill, exp_iv, exp_ill);
      end
      nchk++;
      if (obs_instr !== exp_instr || obs_a !== exp_a || obs_b !== exp_b) begin
        nerr++;
        $display("FAIL rand_issue cyc=%0d got %h %h %h exp %h %h %h",
                 cyc, obs_instr, obs_a, obs_b, exp_instr, exp_a, exp_b);
      end
    end
    idle(LAT + 1);
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_dependent();
    test_x0();
    test_illegal();
    test_dbg_collision();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
# operand_issue

Operand-fetch and issue stage directly upstream of `processor`. Accepts RV32 R-type instructions over a valid/ready handshake and reads rs1/rs2 from a 32×32 register file. It drives `instruction`, `a` and `b` into the processor, then writes the processor result `y` back to rd after a fixed execute latency. A scoreboard of in-flight destinations stalls issue on read-after-write hazards.

## Interface
- `EXEC_LAT`, 1: cycles from issue until `y` is valid for that instruction (1–4).
- `XLEN`, 32: data width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream instruction valid.
- `in_instr` in 32: upstream instruction word.
- `in_ready` out 1: stage can accept this cycle.
- `instruction` out 32: instruction presented to the processor.
- `a` out XLEN: rs1 operand.
- `b` out XLEN: rs2 operand.
- `issue_valid` out 1: one-cycle pulse; `instruction`/`a`/`b` are newly issued.
- `y` in XLEN: processor result.
- `retire_valid` out 1: a writeback happened this cycle.
- `retire_rd` out 5: rd written this cycle.
- `illegal` out 1: one-cycle pulse; accepted word was not opcode 0110011, so it was dropped.
- `dbg_we` in 1: bench preload write enable.
- `dbg_addr` in 5: preload address.
- `dbg_wdata` in XLEN: preload data.

## Operation
- Fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Accept happens when `in_valid && in_ready`.
- `in_ready` = !hazard.
  - hazard = (rs1≠0 and rs1 matches a pending rd) or (rs2≠0 and rs2 matches a pending rd).
  - "pending" = any valid scoreboard entry, including one issuing this cycle.
- On an accepted legal word: register `instruction`, `a` = RF[rs1], `b` = RF[rs2], pulse `issue_valid`, push {1, rd} into the scoreboard.
  - rd=0 pushes valid=0.
- On an accepted illegal opcode: pulse `illegal`. No issue, no scoreboard push, and `instruction`/`a`/`b` hold.
- Scoreboard: EXEC_LAT-deep shift register of {valid, rd}, shifting every cycle. The entry leaving the tail is the writeback for the current `y`.
- Writeback: when the tail is valid, RF[rd] ← `y` at the clock edge, with `retire_valid`=1 and `retire_rd`=rd in the same cycle.
- Register x0 always reads 0. Writes to x0 from writeback and debug are ignored.
- Debug write: RF[dbg_addr] ← dbg_wdata at the edge. If it targets the same address as a writeback in the same cycle, the writeback wins.
- Outputs hold their last issued values between issues.

## Timing
- Reset values (async):
  - RF all 0 and scoreboard all invalid.
  - `instruction`, `a`, `b` = 0.
  - `issue_valid`, `retire_valid`, `illegal` = 0 and `retire_rd` = 0.
  - `in_ready` = 1 once reset deasserts.
- Accept at edge T gives outputs valid after T, with `issue_valid` high during cycle T+1.
- `y` is sampled EXEC_LAT cycles after the issue cycle, and RF is updated at that edge.
- Back-to-back independent instructions issue every cycle.
- A dependent instruction (without forwarding) waits until the producer's writeback edge. It is accepted on the next edge and reads the new value.
- `rst` asserted mid-operation discards in-flight writebacks. No RF write occurs for them.

## Configuration
- `OPISSUE_FWD_EN` defined: a hazard whose only match is the tail entry, which retires this cycle, does not stall. The operand is taken from `y` directly, so a dependent instruction issues in the producer's writeback cycle.
- `OPISSUE_FWD_EN` undefined: the same case stalls one extra cycle and the operand is read from RF.

## Structure
- Shared package `cpu_pkg` holds:
  - `OPC_RTYPE` = 7'b0110011.
  - Field-position localparams.
  - A `rtype_t` struct {funct7, rs2, rs1, funct3, rd, opcode}.
- One sub-module, `regfile_2r1w`: two combinational read ports, one write port, x0 hardwired to 0, and the debug write port merged in with writeback priority.
- Top level holds the scoreboard, hazard logic and issue registers.

## Test plan
- Preload x1=0x0000000F, x2=0x0000000C. Send ADD x3,x1,x2 (0x002081B3) → `issue_valid` pulse with a=0x0F, b=0x0C. Drive y=0x1B at issue+EXEC_LAT → `retire_rd`=3 and RF[3]=0x1B.
- ADD x3,x1,x2 followed immediately by SUB x4,x3,x1 (0x40118233):
  - Without FWD → `in_ready`=0 until writeback, then a=0x1B.
  - With FWD → issues in the writeback cycle with a=y.
- ADD x0,x1,x2 then ADD x5,x0,x1 → no stall, `retire_valid` stays 0 for rd=0, a=0.
- Word 0x00000013 (opcode 0010011) → `illegal` pulse, no `issue_valid`, outputs unchanged.
- Same-cycle `dbg_we` to x3 (0xDEAD) and writeback to x3 (0x1B) → RF[3]=0x1B.
- Assert `rst` one cycle after issuing ADD x3 → no retire, RF[3]=0, all outputs 0.
